// File: rtl/hms_timekeeper.sv
// hms_timekeeper
//   Time/alarm datapath for the clock controller. Holds clock H:M:S and alarm
//   H:M:S counters, stretches wrap pulses back to the controller (which closes
//   the sec->min->hour carry loop), runs the alarm ring FSM and drives a
//   blink-masked BCD display word. Everything runs on clk.
//
// Ports
//   clk, rst_n          system clock, asynchronous active-low reset
//   i_mode[1:0]         0=CLOCK 1=SETUP 2=ALARM 3=CLOCK
//   i_position[1:0]     0=SEC 1=MIN 2=HOUR 3=none
//   i_*_clk             increment strobes (asynchronous, rising edge = +1)
//   i_alarm_en          alarm armed (level)
//   i_blink             1 Hz blink square wave (asynchronous level)
//   o_max_hit_*         stretched wrap pulses of the clock counters
//   o_alarm             alarm ringing
//   o_disp_bcd[23:0]    {hour_t,hour_u,min_t,min_u,sec_t,sec_u}
module hms_timekeeper #(
  parameter int HIT_CYCLES = 4,
  parameter int RING_SEC   = 30,
  parameter int HOUR_MAX   = 24
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  i_mode,
  input  logic [1:0]  i_position,
  input  logic        i_sec_clk,
  input  logic        i_min_clk,
  input  logic        i_hour_clk,
  input  logic        i_alarm_sec_clk,
  input  logic        i_alarm_min_clk,
  input  logic        i_alarm_hour_clk,
  input  logic        i_alarm_en,
  input  logic        i_blink,
  output logic        o_max_hit_sec,
  output logic        o_max_hit_min,
  output logic        o_max_hit_hour,
  output logic        o_alarm,
  output logic [23:0] o_disp_bcd
);

  localparam int SEC   = 0;
  localparam int MIN   = 1;
  localparam int HOUR  = 2;
  localparam int ASEC  = 3;
  localparam int AMIN  = 4;
  localparam int AHOUR = 5;

  typedef enum logic {IDLE, RING} alarmState_e;

  logic [5:0]       strobeRaw;
  logic [5:0]       sync1_q, sync2_q, prev_q, inc_q;
  logic             blinkSync1_q, blinkSync2_q;
  logic [5:0]       sec_q, sec_d, min_q, min_d;
  logic [4:0]       hour_q, hour_d;
  logic [5:0]       alarmSec_q, alarmSec_d, alarmMin_q, alarmMin_d;
  logic [4:0]       alarmHour_q, alarmHour_d;
  logic [2:0]       wrap;
  logic [2:0][7:0]  hitCnt_q;
  logic [2:0]       hit_q;
  alarmState_e      state_q, state_d;
  logic [7:0]       ringCnt_q, ringCnt_d;
  logic             clockMatch;
  logic [5:0]       srcSec, srcMin;
  logic [4:0]       srcHour;
  logic [7:0]       bcdSec, bcdMin, bcdHour;
  logic             blinkMask;
  logic [23:0]      disp_d, disp_q;

  function automatic logic [5:0] incMod60(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] incHour(input logic [4:0] v);
    return (v == 5'(HOUR_MAX - 1)) ? 5'd0 : v + 5'd1;
  endfunction

  function automatic logic [7:0] toBcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  assign strobeRaw = {i_alarm_hour_clk, i_alarm_min_clk, i_alarm_sec_clk,
                      i_hour_clk, i_min_clk, i_sec_clk};

  // Two-flop synchronizers, then a registered rising-edge detect so every
  // increment is a single-cycle strobe three cycles after the input edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      prev_q       <= '0;
      inc_q        <= '0;
      blinkSync1_q <= 1'b0;
      blinkSync2_q <= 1'b0;
    end else begin
      sync1_q      <= strobeRaw;
      sync2_q      <= sync1_q;
      prev_q       <= sync2_q;
      inc_q        <= sync2_q & ~prev_q;
      blinkSync1_q <= i_blink;
      blinkSync2_q <= blinkSync1_q;
    end
  end

  // The six counters are independent; carries only arrive through the
  // controller feeding the wrap pulses back in as strobes.
  assign sec_d       = inc_q[SEC]   ? incMod60(sec_q)      : sec_q;
  assign min_d       = inc_q[MIN]   ? incMod60(min_q)      : min_q;
  assign hour_d      = inc_q[HOUR]  ? incHour(hour_q)      : hour_q;
  assign alarmSec_d  = inc_q[ASEC]  ? incMod60(alarmSec_q) : alarmSec_q;
  assign alarmMin_d  = inc_q[AMIN]  ? incMod60(alarmMin_q) : alarmMin_q;
  assign alarmHour_d = inc_q[AHOUR] ? incHour(alarmHour_q) : alarmHour_q;

  assign wrap[0] = inc_q[SEC]  && (sec_q == 6'd59);
  assign wrap[1] = inc_q[MIN]  && (min_q == 6'd59);
  assign wrap[2] = inc_q[HOUR] && (hour_q == 5'(HOUR_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q       <= '0;
      min_q       <= '0;
      hour_q      <= '0;
      alarmSec_q  <= '0;
      alarmMin_q  <= '0;
      alarmHour_q <= '0;
    end else begin
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      alarmSec_q  <= alarmSec_d;
      alarmMin_q  <= alarmMin_d;
      alarmHour_q <= alarmHour_d;
    end
  end

  // A wrap (re)loads the stretch counter; the output flop follows
  // "counter non-zero", so the pulse starts one cycle after the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hitCnt_q <= '0;
      hit_q    <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (wrap[i]) begin
          hitCnt_q[i] <= 8'(HIT_CYCLES);
        end else if (hitCnt_q[i] != 8'd0) begin
          hitCnt_q[i] <= hitCnt_q[i] - 8'd1;
        end
        hit_q[i] <= (hitCnt_q[i] != 8'd0);
      end
    end
  end

  assign o_max_hit_sec  = hit_q[0];
  assign o_max_hit_min  = hit_q[1];
  assign o_max_hit_hour = hit_q[2];

  // The match uses the clock's next value so only a clock-second strobe
  // arriving at the alarm time triggers; alarm edits never do.
  assign clockMatch = ({hour_d, min_d, sec_d} == {alarmHour_q, alarmMin_q, alarmSec_q});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ringCnt_q <= '0;
    end else begin
      state_q   <= state_d;
      ringCnt_q <= ringCnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ringCnt_d = ringCnt_q;
    case (state_q)
      IDLE: begin
        if (i_alarm_en && inc_q[SEC] && clockMatch) begin
          state_d   = RING;
          ringCnt_d = 8'(RING_SEC);
        end
      end
      RING: begin
        if (!i_alarm_en) begin
          state_d   = IDLE;
          ringCnt_d = 8'd0;
        end else if (inc_q[SEC]) begin
          ringCnt_d = ringCnt_q - 8'd1;
          if (ringCnt_q == 8'd1) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_alarm = (state_q == RING);

  // Blink mask uses the synchronized blink so it only blanks while the wave is low.
  assign blinkMask = ((i_mode == 2'd1) || (i_mode == 2'd2)) && (i_position != 2'd3) && !blinkSync2_q;

  always_comb begin
    srcSec  = sec_q;
    srcMin  = min_q;
    srcHour = hour_q;
    if (i_mode == 2'd2) begin
      srcSec  = alarmSec_q;
      srcMin  = alarmMin_q;
      srcHour = alarmHour_q;
    end
    bcdSec  = toBcd(srcSec);
    bcdMin  = toBcd(srcMin);
    bcdHour = toBcd({1'b0, srcHour});
    if (blinkMask) begin
      case (i_position)
        2'd0:    bcdSec  = 8'hFF;
        2'd1:    bcdMin  = 8'hFF;
        2'd2:    bcdHour = 8'hFF;
        default: ;
      endcase
    end
    disp_d = {bcdHour, bcdMin, bcdSec};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_q <= '0;
    end else begin
      disp_q <= disp_d;
    end
  end

  assign o_disp_bcd = disp_q;

endmodule

// File: tb/tb_hms_timekeeper.sv
// tb_hms_timekeeper
//   Self-checking bench for hms_timekeeper: table of display/blink vectors,
//   hand-written sequences for wrap, carry loop and alarm corners, and random
//   strobe traffic checked against an arithmetic model of the time counters.
module tb_hms_timekeeper;

  localparam int HIT_CYCLES = 4;
  localparam int RING_SEC   = 30;
  localparam int HOUR_MAX   = 24;

  typedef struct packed {
    logic [1:0]  mode;
    logic [1:0]  pos;
    logic        blink;
    logic [23:0] disp;
  } dispVec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  mode = 2'd0;
  logic [1:0]  position = 2'd3;
  logic [5:0]  strobe = 6'd0;
  logic        loopMode = 1'b0;
  logic        alarmEn = 1'b0;
  logic        blink = 1'b1;
  logic        hitSec, hitMin, hitHour, alarmOut;
  logic [23:0] disp;
  logic        minClk, hourClk;

  int testsRun = 0;
  int testsFailed = 0;
  int hitTotal[3];
  int gotHit[3];
  int wantHit[3];
  int mSec, mMin, mHour, aSec, aMin, aHour, ringLeft;
  dispVec_t vecs[11];

  // Closing the carry loop the way the controller does it.
  assign minClk  = loopMode ? hitSec : strobe[1];
  assign hourClk = loopMode ? hitMin : strobe[2];

  hms_timekeeper #(.HIT_CYCLES(HIT_CYCLES), .RING_SEC(RING_SEC), .HOUR_MAX(HOUR_MAX)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_mode           (mode),
    .i_position       (position),
    .i_sec_clk        (strobe[0]),
    .i_min_clk        (minClk),
    .i_hour_clk       (hourClk),
    .i_alarm_sec_clk  (strobe[3]),
    .i_alarm_min_clk  (strobe[4]),
    .i_alarm_hour_clk (strobe[5]),
    .i_alarm_en       (alarmEn),
    .i_blink          (blink),
    .o_max_hit_sec    (hitSec),
    .o_max_hit_min    (hitMin),
    .o_max_hit_hour   (hitHour),
    .o_alarm          (alarmOut),
    .o_disp_bcd       (disp)
  );

  always #10 clk = ~clk;

  // Running totals of high cycles on each wrap output.
  initial begin
    for (int i = 0; i < 3; i++) hitTotal[i] = 0;
    forever begin
      @(negedge clk);
      if (hitSec)  hitTotal[0]++;
      if (hitMin)  hitTotal[1]++;
      if (hitHour) hitTotal[2]++;
    end
  end

  initial begin
    #(20 * 60000);
    $display("[TB] FAIL watchdog: simulation still running after 60000 cycles, expected to finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic logic [23:0] expDisp(input int md, input int pos, input logic bl);
    int h, m, s;
    logic [7:0] ph, pm, ps;
    h = mHour; m = mMin; s = mSec;
    if (md == 2) begin
      h = aHour; m = aMin; s = aSec;
    end
    ph = {4'(h / 10), 4'(h % 10)};
    pm = {4'(m / 10), 4'(m % 10)};
    ps = {4'(s / 10), 4'(s % 10)};
    if ((md == 1 || md == 2) && pos < 3 && !bl) begin
      if (pos == 0) ps = 8'hFF;
      if (pos == 1) pm = 8'hFF;
      if (pos == 2) ph = 8'hFF;
    end
    return {ph, pm, ps};
  endfunction

  function automatic int modelVal(input int idx);
    case (idx)
      0: return mSec;
      1: return mMin;
      2: return mHour;
      3: return aSec;
      4: return aMin;
      default: return aHour;
    endcase
  endfunction

  task automatic clearModel();
    mSec = 0; mMin = 0; mHour = 0; aSec = 0; aMin = 0; aHour = 0; ringLeft = 0;
  endtask

  // Reset is checked while still asserted, before any clock edge, so the
  // clear must be asynchronous.
  task automatic resetDut(input string tag);
    @(negedge clk);
    strobe = 6'd0;
    loopMode = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput({tag, " reset disp"}, 32'(disp), 32'h0);
    checkOutput({tag, " reset alarm"}, 32'(alarmOut), 32'h0);
    checkOutput({tag, " reset hits"}, 32'({hitHour, hitMin, hitSec}), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clearModel();
    repeat (2) @(negedge clk);
  endtask

  // One strobe event: raise the selected inputs, let them settle, and move
  // the model forward by the same event.
  task automatic applyStimulus(input logic [5:0] mask, input int settle);
    int snap[3];
    int oaS, oaM, oaH;
    bit secW, minW, hourW;
    for (int i = 0; i < 3; i++) snap[i] = hitTotal[i];
    @(negedge clk);
    strobe = mask;
    repeat (6) @(negedge clk);
    strobe = 6'd0;
    repeat (6 + settle) @(negedge clk);
    for (int i = 0; i < 3; i++) gotHit[i] = hitTotal[i] - snap[i];

    oaS = aSec; oaM = aMin; oaH = aHour;
    secW = 0; minW = 0; hourW = 0;
    if (!alarmEn) ringLeft = 0;
    if (mask[0]) begin
      mSec = (mSec + 1) % 60;
      secW = (mSec == 0);
    end
    if (!loopMode && mask[1]) begin
      mMin = (mMin + 1) % 60;
      minW = (mMin == 0);
    end
    if (!loopMode && mask[2]) begin
      mHour = (mHour + 1) % HOUR_MAX;
      hourW = (mHour == 0);
    end
    if (mask[3]) aSec  = (aSec + 1) % 60;
    if (mask[4]) aMin  = (aMin + 1) % 60;
    if (mask[5]) aHour = (aHour + 1) % HOUR_MAX;
    if (mask[0]) begin
      if (ringLeft > 0) ringLeft--;
      else if (alarmEn && mHour == oaH && mMin == oaM && mSec == oaS) ringLeft = RING_SEC;
    end
    if (loopMode && secW) begin
      mMin = (mMin + 1) % 60;
      minW = (mMin == 0);
      if (minW) begin
        mHour = (mHour + 1) % HOUR_MAX;
        hourW = (mHour == 0);
      end
    end
    wantHit[0] = secW  ? HIT_CYCLES : 0;
    wantHit[1] = minW  ? HIT_CYCLES : 0;
    wantHit[2] = hourW ? HIT_CYCLES : 0;
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, " disp"}, 32'(disp), 32'(expDisp(int'(mode), int'(position), blink)));
    checkOutput({tag, " alarm"}, 32'(alarmOut), (ringLeft > 0) ? 32'd1 : 32'd0);
    checkOutput({tag, " hitSec cycles"}, 32'(gotHit[0]), 32'(wantHit[0]));
    checkOutput({tag, " hitMin cycles"}, 32'(gotHit[1]), 32'(wantHit[1]));
    checkOutput({tag, " hitHour cycles"}, 32'(gotHit[2]), 32'(wantHit[2]));
  endtask

  task automatic advanceTo(input int idx, input int target);
    for (int k = 0; k < 70; k++) begin
      if (modelVal(idx) == target) break;
      applyStimulus(6'(1 << idx), 0);
    end
  endtask

  initial begin
    int firstWrap, firstHit, highCount;

    // Clock 02:07:35, alarm 00:00:03 for the display table.
    vecs[0]  = '{2'd0, 2'd1, 1'b0, 24'h020735};
    vecs[1]  = '{2'd1, 2'd1, 1'b0, 24'h02FF35};
    vecs[2]  = '{2'd1, 2'd1, 1'b1, 24'h020735};
    vecs[3]  = '{2'd0, 2'd1, 1'b0, 24'h020735};
    vecs[4]  = '{2'd1, 2'd0, 1'b0, 24'h0207FF};
    vecs[5]  = '{2'd1, 2'd2, 1'b0, 24'hFF0735};
    vecs[6]  = '{2'd1, 2'd3, 1'b0, 24'h020735};
    vecs[7]  = '{2'd2, 2'd1, 1'b1, 24'h000003};
    vecs[8]  = '{2'd2, 2'd0, 1'b0, 24'h0000FF};
    vecs[9]  = '{2'd3, 2'd1, 1'b0, 24'h020735};
    vecs[10] = '{2'd2, 2'd2, 1'b0, 24'hFF0003};

    clearModel();
    resetDut("t1");

    // Five clock seconds.
    mode = 2'd0; position = 2'd3; blink = 1'b1; alarmEn = 1'b0;
    for (int k = 0; k < 5; k++) applyStimulus(6'b000001, 0);
    checkOutput("t1 disp after 5 sec", 32'(disp), 32'h000005);
    checkAll("t1");

    // Random strobe traffic with the alarm armed.
    alarmEn = 1'b1;
    for (int k = 0; k < 400; k++) begin
      mode     = 2'($urandom_range(0, 3));
      position = 2'($urandom_range(0, 3));
      blink    = 1'($urandom_range(0, 1));
      applyStimulus(6'($urandom_range(0, 63)), 0);
      checkAll("random");
    end

    // Second wrap: exact latency and pulse length.
    alarmEn = 1'b0;
    resetDut("t2");
    mode = 2'd0; position = 2'd3; blink = 1'b1;
    advanceTo(0, 59);
    checkOutput("t2 disp at 59", 32'(disp), 32'h000059);
    firstWrap = -1; firstHit = -1; highCount = 0;
    @(negedge clk);
    strobe[0] = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clk);
      if (c == 6) strobe[0] = 1'b0;
      if (firstWrap < 0 && disp[7:0] == 8'h00) firstWrap = c;
      if (hitSec) begin
        if (firstHit < 0) firstHit = c;
        highCount++;
      end
    end
    mSec = 0;
    checkOutput("t2 disp wrap cycle", 32'(firstWrap), 32'd5);
    checkOutput("t2 hitSec first cycle", 32'(firstHit), 32'd5);
    checkOutput("t2 hitSec high cycles", 32'(highCount), 32'(HIT_CYCLES));
    checkOutput("t2 disp after wrap", 32'(disp), 32'h000000);
    checkOutput("t2 min/hour hits", 32'({hitHour, hitMin}), 32'h0);

    // Carry loop: 00:59:59 -> 01:00:00. The hour counter only steps, so the
    // minute pulse (which is the hour strobe here) fires but the hour wrap does not.
    advanceTo(1, 59);
    advanceTo(0, 59);
    loopMode = 1'b1;
    applyStimulus(6'b000001, 30);
    loopMode = 1'b0;
    checkOutput("t3 loop disp", 32'(disp), 32'h010000);
    checkAll("t3");

    // Hour wrap leaves minutes and seconds alone.
    advanceTo(1, 34);
    advanceTo(0, 12);
    advanceTo(2, 23);
    checkOutput("t4 disp at 23", 32'(disp), 32'h233412);
    applyStimulus(6'b000100, 0);
    checkOutput("t4 disp after hour wrap", 32'(disp), 32'h003412);
    checkAll("t4");

    // Alarm at 00:00:10.
    resetDut("t5");
    mode = 2'd0; position = 2'd3; blink = 1'b1; alarmEn = 1'b0;
    advanceTo(3, 10);
    advanceTo(0, 9);
    alarmEn = 1'b1;
    applyStimulus(6'b000001, 0);
    checkOutput("t5 alarm starts", 32'(alarmOut), 32'd1);
    for (int k = 1; k <= RING_SEC; k++) begin
      applyStimulus(6'b000001, 0);
      if (k == RING_SEC - 1) checkOutput("t5 alarm still ringing", 32'(alarmOut), 32'd1);
      if (k == RING_SEC) checkOutput("t5 alarm ends", 32'(alarmOut), 32'd0);
    end
    checkAll("t5 after ring");
    advanceTo(0, 9);
    applyStimulus(6'b000001, 0);
    checkOutput("t5 alarm restarts", 32'(alarmOut), 32'd1);
    for (int k = 0; k < 3; k++) applyStimulus(6'b000001, 0);
    checkAll("t5 mid ring");
    alarmEn = 1'b0;
    ringLeft = 0;
    @(negedge clk);
    checkOutput("t5 alarm_en drop", 32'(alarmOut), 32'd0);
    alarmEn = 1'b1;
    advanceTo(0, 9);
    applyStimulus(6'b000001, 0);
    checkOutput("t5 alarm before reset", 32'(alarmOut), 32'd1);
    resetDut("t5 mid ring");

    // Display source and blink mask table.
    alarmEn = 1'b0; mode = 2'd0; position = 2'd3; blink = 1'b1;
    advanceTo(2, 2);
    advanceTo(1, 7);
    advanceTo(0, 35);
    advanceTo(3, 3);
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      mode     = vecs[k].mode;
      position = vecs[k].pos;
      blink    = vecs[k].blink;
      repeat (5) @(negedge clk);
      checkOutput($sformatf("t6 vector %0d disp", k), 32'(disp), 32'(vecs[k].disp));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
